vram_text_writer: RTL and testbench
===================================

Name: vram_text_writer

Overview:
- Write side of the 32x24 character video RAM that the VGA scan-out reads.
- Accepts a byte stream (ASCII plus a few control codes) on a valid/ready handshake and maintains a cursor.
- Writes characters at `col + 32*row`; handles newline, backspace, clear-screen and hardware scroll-up (row copy through the RAM's read port).
- Sits between the CPU/terminal logic and the write port of the dual-port video RAM.

Parameters:
- COLS, 32, characters per row (power of two; address = col + COLS*row).
- ROWS, 24, text rows.
- BLANK, 8'h20, fill character for clear/scroll/backspace.
- CLEAR_ON_RESET, 1, run a full-screen clear automatically after reset release.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_valid  in  1  ch_data holds a byte to consume.
- ch_data  in  8  character or control code.
- ch_ready  out  1  block can accept this cycle; transfer = ch_valid & ch_ready.
- v_ram_wa  out  11  video RAM write address.
- v_ram_do  out  8  video RAM write data.
- v_ram_we  out  1  video RAM write enable, one write per cycle max.
- v_ram_ra  out  11  video RAM read address (scroll only).
- v_ram_ri  in  8  read data, valid exactly 1 cycle after v_ram_ra (synchronous RAM).
- cur_col  out  5  cursor column 0..COLS-1.
- cur_row  out  5  cursor row 0..ROWS-1.
- busy  out  1  clear or scroll in progress.

Behaviour:
- Reset (async, rst_n low):
  - ch_ready=0, v_ram_we=0, v_ram_wa=0, v_ram_do=0, v_ram_ra=0, busy=0, cursor=(0,0).
  - Any in-progress clear/scroll is aborted.
  - After release: state CLEAR if CLEAR_ON_RESET, else IDLE.
- FSM states: IDLE, PUT, COPY, FILL, CLEAR.
  - ch_ready = (state==IDLE). busy = state in {COPY, FILL, CLEAR}.
- IDLE, on transfer, decode ch_data:
  - 0x0D CR: col=0; no write; stay IDLE.
  - 0x0A LF: col=0; if row<ROWS-1 then row+1 → IDLE, else → COPY (row stays ROWS-1).
  - 0x08 BS: if col>0: col-1, then PUT writes BLANK at the new position. If col=0: no-op, no wrap to previous row.
  - 0x0C FF: cursor=(0,0) → CLEAR.
  - Any other byte (including non-printables): → PUT with that byte at the current cursor.
- PUT (exactly 1 cycle):
  - v_ram_we=1, v_ram_wa=col+COLS*row (row in bits [9:5], col in [4:0]), v_ram_do=byte.
  - Non-BS: col+1. At col=COLS-1, col wraps to 0 and the LF row rule applies (may go → COPY). Otherwise → IDLE.
  - Printable throughput: 1 char per 2 cycles.
- COPY (scroll rows 1..ROWS-1 up by one):
  - Index i=0..(ROWS-1)*COLS.
  - Cycle i with i<736: v_ram_ra = i+COLS.
  - Cycle i with i≥1: write v_ram_wa=i-1, v_ram_do=v_ram_ri.
  - 737 cycles, then → FILL.
- FILL: write BLANK to addresses (ROWS-1)*COLS..ROWS*COLS-1 (736..767), one per cycle, 32 cycles → IDLE.
- CLEAR: write BLANK to 0..767, one per cycle, 768 cycles → IDLE.
- v_ram_we=0 in IDLE and in COPY cycle 0. v_ram_ra holds its last value outside COPY.
- Addresses ≥768 are never written. The 11-bit address upper bit is always 0.
- Input bytes arriving while busy wait (ch_ready=0). No byte is dropped or duplicated.
- Cursor outputs update on the edge that completes PUT/decoding. During COPY/FILL they are stable at (0, ROWS-1).

Decomposition:
- Package cobra_video_pkg:
  - COLS, ROWS, VRAM_AW=11, VRAM_CELLS=768.
  - Control-code constants CH_CR, CH_LF, CH_BS, CH_FF, CH_BLANK.
  - writer state enum.
- The same package is shared with the VGA scan-out for geometry.
- No sub-module: a single FSM plus one shared 10-bit index counter covers COPY/FILL/CLEAR.

Test Plan:
- Reset, CLEAR_ON_RESET=1 → busy=1 for 768 cycles, all cells 0x20, ch_ready rises afterwards, cursor (0,0).
- Send "AB" → cell 0=0x41, cell 1=0x42, cursor (2,0), each v_ram_we pulse exactly one cycle.
- Cursor (31,5), send 'Z' → cell 191=0x5A, cursor (0,6). Then BS at col 0 → nothing written, cursor unchanged.
- Row 23, LF with rows filled by pattern cell=addr[7:0] → cell n (n<736) = old cell n+32, cells 736..767=0x20, cursor (0,23), busy 769 cycles.
- ch_valid held high with "X", FF, "Y" back-to-back → X written, screen cleared, Y at cell 0; no byte lost while ch_ready low.
- Assert rst_n low mid-COPY → outputs 0 immediately (async), after release full clear then IDLE.

Source files
------------

// File: rtl/cobra_video_pkg.sv
// Shared text-mode geometry, control codes and writer state encoding for the
// character video RAM (also used by the VGA scan-out).
package cobra_video_pkg;

  localparam int unsigned COLS       = 32;
  localparam int unsigned ROWS       = 24;
  localparam int unsigned VRAM_AW    = 11;
  localparam int unsigned VRAM_CELLS = COLS * ROWS;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_BLANK = 8'h20;

  typedef logic [2:0] writer_state_t;

  localparam writer_state_t ST_IDLE  = 3'd0;
  localparam writer_state_t ST_PUT   = 3'd1;
  localparam writer_state_t ST_COPY  = 3'd2;
  localparam writer_state_t ST_FILL  = 3'd3;
  localparam writer_state_t ST_CLEAR = 3'd4;

endpackage

// File: rtl/vram_text_writer.sv
// Write side of the text video RAM: consumes a byte stream, keeps a cursor,
// and performs clear-screen and scroll-up using the RAM's read port.
module vram_text_writer #(
  parameter int unsigned COLS           = cobra_video_pkg::COLS,
  parameter int unsigned ROWS           = cobra_video_pkg::ROWS,
  parameter logic [7:0]  BLANK          = cobra_video_pkg::CH_BLANK,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ch_valid,
  input  logic [7:0]                          ch_data,
  output logic                                ch_ready,
  output logic [cobra_video_pkg::VRAM_AW-1:0] v_ram_wa,
  output logic [7:0]                          v_ram_do,
  output logic                                v_ram_we,
  output logic [cobra_video_pkg::VRAM_AW-1:0] v_ram_ra,
  input  logic [7:0]                          v_ram_ri,
  output logic [4:0]                          cur_col,
  output logic [4:0]                          cur_row,
  output logic                                busy
);
  import cobra_video_pkg::*;

  localparam int unsigned CELLS     = COLS * ROWS;
  localparam int unsigned COPY_LAST = (ROWS - 1) * COLS;

  localparam logic [4:0] COL_MAX       = 5'(COLS - 1);
  localparam logic [4:0] ROW_MAX       = 5'(ROWS - 1);
  localparam logic [9:0] IDX_COPY_LAST = 10'(COPY_LAST);
  localparam logic [9:0] IDX_CELL_LAST = 10'(CELLS - 1);
  localparam logic [9:0] IDX_ROW_STEP  = 10'(COLS);

  localparam writer_state_t ST_AFTER_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  writer_state_t state_q, state_d;
  logic [4:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic [7:0]    byte_q, byte_d;
  logic          bs_q, bs_d;
  logic [9:0]    idx_q, idx_d;
  logic [9:0]    ra_q, ra_d;

  logic          transfer;
  logic [9:0]    cell_addr;
  logic          we_c;
  logic [9:0]    wa_c;
  logic [7:0]    do_c;

  assign transfer  = ch_valid & ch_ready;
  assign cell_addr = 10'((32'(row_q) * COLS) + 32'(col_q));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    byte_d  = byte_q;
    bs_d    = bs_q;
    idx_d   = idx_q;
    ra_d    = ra_q;

    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          case (ch_data)
            CH_CR: col_d = 5'd0;
            CH_LF: begin
              col_d = 5'd0;
              if (row_q < ROW_MAX) begin
                row_d = row_q + 5'd1;
              end else begin
                state_d = ST_COPY;
                idx_d   = 10'd0;
              end
            end
            CH_BS: begin
              // Backspace never wraps to the previous row.
              if (col_q != 5'd0) begin
                col_d   = col_q - 5'd1;
                byte_d  = BLANK;
                bs_d    = 1'b1;
                state_d = ST_PUT;
              end
            end
            CH_FF: begin
              col_d   = 5'd0;
              row_d   = 5'd0;
              idx_d   = 10'd0;
              state_d = ST_CLEAR;
            end
            default: begin
              byte_d  = ch_data;
              bs_d    = 1'b0;
              state_d = ST_PUT;
            end
          endcase
        end
      end

      ST_PUT: begin
        state_d = ST_IDLE;
        if (!bs_q) begin
          if (col_q == COL_MAX) begin
            col_d = 5'd0;
            if (row_q < ROW_MAX) begin
              row_d = row_q + 5'd1;
            end else begin
              state_d = ST_COPY;
              idx_d   = 10'd0;
            end
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end

      ST_COPY: begin
        // Read runs one index ahead of the write (synchronous RAM read).
        if (idx_q < IDX_COPY_LAST) begin
          ra_d = idx_q + IDX_ROW_STEP;
        end
        if (idx_q == IDX_COPY_LAST) begin
          state_d = ST_FILL;
        end else begin
          idx_d = idx_q + 10'd1;
        end
      end

      ST_FILL, ST_CLEAR: begin
        if (idx_q == IDX_CELL_LAST) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 10'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    we_c = 1'b0;
    wa_c = 10'd0;
    do_c = 8'd0;
    case (state_q)
      ST_PUT: begin
        we_c = 1'b1;
        wa_c = cell_addr;
        do_c = byte_q;
      end
      ST_COPY: begin
        if (idx_q != 10'd0) begin
          we_c = 1'b1;
          wa_c = idx_q - 10'd1;
          do_c = v_ram_ri;
        end
      end
      ST_FILL, ST_CLEAR: begin
        we_c = 1'b1;
        wa_c = idx_q;
        do_c = BLANK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_AFTER_RESET;
      col_q   <= 5'd0;
      row_q   <= 5'd0;
      byte_q  <= 8'd0;
      bs_q    <= 1'b0;
      idx_q   <= 10'd0;
      ra_q    <= 10'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      byte_q  <= byte_d;
      bs_q    <= bs_d;
      idx_q   <= idx_d;
      ra_q    <= ra_d;
    end
  end

  // State resets straight into CLEAR so the clear starts on the first edge after
  // release; outputs are held quiet while rst_n is low.
  assign ch_ready = rst_n & (state_q == ST_IDLE);
  assign busy     = rst_n & ((state_q == ST_COPY) | (state_q == ST_FILL) |
                             (state_q == ST_CLEAR));
  assign v_ram_we = rst_n & we_c;
  assign v_ram_wa = rst_n ? {1'b0, wa_c} : '0;
  assign v_ram_do = rst_n ? do_c : 8'd0;
  assign v_ram_ra = {1'b0, ra_d};
  assign cur_col  = col_q;
  assign cur_row  = row_q;

endmodule

// File: tb/tb_vram_text_writer.sv
// Directed bench for vram_text_writer with a synchronous dual-port RAM model.
module tb_vram_text_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic [10:0] v_ram_wa;
  logic [7:0]  v_ram_do;
  logic        v_ram_we;
  logic [10:0] v_ram_ra;
  logic [7:0]  v_ram_ri;
  logic [4:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int bad_addr = 0;
  bit saw_x    = 1'b0;

  logic [7:0] mem [0:2047];
  logic       preload;

  always #5 clk = ~clk;

  vram_text_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .v_ram_wa (v_ram_wa),
    .v_ram_do (v_ram_do),
    .v_ram_we (v_ram_we),
    .v_ram_ra (v_ram_ra),
    .v_ram_ri (v_ram_ri),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy)
  );

  // RAM model; preload fills cell n with n[7:0] for the scroll test.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 768; i++) mem[i] <= i[7:0];
    end else if (v_ram_we) begin
      mem[v_ram_wa] <= v_ram_do;
    end
    v_ram_ri <= mem[v_ram_ra];
  end

  always @(posedge clk) begin
    if (v_ram_we) begin
      wr_count++;
      if (v_ram_wa >= 11'd768) bad_addr++;
      if (v_ram_wa == 11'd736 && v_ram_do == 8'h58) saw_x = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit hold);
    int t;
    t = 0;
    ch_data  = b;
    ch_valid = 1'b1;
    @(negedge clk);
    while (!ch_ready && t < 3000) begin
      t++;
      @(negedge clk);
    end
    if (!ch_ready) check_eq("send_timeout", int'(ch_ready), 1);
    @(posedge clk);
    #1;
    if (!hold) ch_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int blank_errs(input int lo, input int hi);
    int e;
    e = 0;
    for (int i = lo; i <= hi; i++) if (mem[i] !== 8'h20) e++;
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, int'(ch_ready), 0);
    check_eq({tag, "_we"},    int'(v_ram_we), 0);
    check_eq({tag, "_wa"},    int'(v_ram_wa), 0);
    check_eq({tag, "_do"},    int'(v_ram_do), 0);
    check_eq({tag, "_ra"},    int'(v_ram_ra), 0);
    check_eq({tag, "_busy"},  int'(busy), 0);
    check_eq({tag, "_col"},   int'(cur_col), 0);
    check_eq({tag, "_row"},   int'(cur_row), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int w0;
    int errs;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    preload  = 1'b0;

    #12;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Power-up clear
    wait_idle(n);
    check_eq("clear_cycles", n, 768);
    check_eq("clear_cells", blank_errs(0, 767), 0);
    check_eq("clear_ready", int'(ch_ready), 1);
    check_eq("clear_col", int'(cur_col), 0);
    check_eq("clear_row", int'(cur_row), 0);

    // "AB"
    w0 = wr_count;
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    settle(1);
    check_eq("ab_cell0", int'(mem[0]), 8'h41);
    check_eq("ab_cell1", int'(mem[1]), 8'h42);
    check_eq("ab_writes", wr_count - w0, 2);
    check_eq("ab_col", int'(cur_col), 2);
    check_eq("ab_row", int'(cur_row), 0);

    // Move to (31,5), then 'Z' wraps to the next row
    send_byte(8'h0D, 1'b0);
    repeat (5) send_byte(8'h0A, 1'b0);
    repeat (31) send_byte(8'h2E, 1'b0);
    settle(1);
    check_eq("pre_z_col", int'(cur_col), 31);
    check_eq("pre_z_row", int'(cur_row), 5);
    send_byte(8'h5A, 1'b0);
    settle(1);
    check_eq("z_cell191", int'(mem[191]), 8'h5A);
    check_eq("z_col", int'(cur_col), 0);
    check_eq("z_row", int'(cur_row), 6);

    // Backspace at column 0 does nothing
    w0 = wr_count;
    send_byte(8'h08, 1'b0);
    settle(1);
    check_eq("bs0_writes", wr_count - w0, 0);
    check_eq("bs0_col", int'(cur_col), 0);
    check_eq("bs0_row", int'(cur_row), 6);

    // Backspace after a character blanks it
    send_byte(8'h51, 1'b0);
    settle(1);
    check_eq("q_cell192", int'(mem[192]), 8'h51);
    send_byte(8'h08, 1'b0);
    settle(1);
    check_eq("bs_cell192", int'(mem[192]), 8'h20);
    check_eq("bs_col", int'(cur_col), 0);
    check_eq("bs_row", int'(cur_row), 6);

    // Scroll from the bottom row
    repeat (17) send_byte(8'h0A, 1'b0);
    settle(1);
    check_eq("pre_scroll_row", int'(cur_row), 23);
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    send_byte(8'h0A, 1'b0);
    wait_idle(n);
    check_eq("scroll_cycles", n, 769);
    errs = 0;
    for (int i = 0; i < 736; i++) begin
      logic [7:0] exp_b;
      exp_b = 8'(i + 32);
      if (mem[i] !== exp_b) errs++;
    end
    check_eq("scroll_copy", errs, 0);
    check_eq("scroll_fill", blank_errs(736, 767), 0);
    check_eq("scroll_col", int'(cur_col), 0);
    check_eq("scroll_row", int'(cur_row), 23);
    check_eq("scroll_ready", int'(ch_ready), 1);

    // Back-to-back "X", FF, "Y" with ch_valid held high
    send_byte(8'h58, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_byte(8'h59, 1'b0);
    settle(1);
    check_eq("b2b_x_written", int'(saw_x), 1);
    check_eq("b2b_cell0", int'(mem[0]), 8'h59);
    check_eq("b2b_cleared", blank_errs(1, 767), 0);
    check_eq("b2b_col", int'(cur_col), 1);
    check_eq("b2b_row", int'(cur_row), 0);

    // Reset in the middle of a scroll
    repeat (24) send_byte(8'h0A, 1'b0);
    settle(100);
    check_eq("mid_copy_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle(n);
    check_eq("reclear_cycles", n, 768);
    check_eq("reclear_cells", blank_errs(0, 767), 0);
    check_eq("reclear_ready", int'(ch_ready), 1);
    check_eq("reclear_col", int'(cur_col), 0);
    check_eq("reclear_row", int'(cur_row), 0);

    check_eq("addr_range", bad_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
